pbch_dmrs_mapper: RTL and testbench
===================================

Name: pbch_dmrs_mapper

Overview:
- Transmit-side counterpart of the PBCH channel estimator.
- From a configured N_id and ibar_SSB, generates the 144-symbol PBCH DMRS Gold sequence (TS 38.211 7.4.1.4) and QPSK-modulates it.
- Streams the 240-subcarrier SSB region of PBCH symbols 1..3 as AXI-stream samples, DMRS at k mod 4 == N_id mod 4, zeros elsewhere.
- Feeds the test-signal/SSB transmitter ahead of the IFFT; lets the receiver's ibar_SSB detection run in closed-loop benches.

Parameters:
- OUT_DW, 32, output sample width; im in the upper half, re in the lower half, each OUT_DW/2 signed.
- AMPL, 11585, QPSK magnitude per component; must fit OUT_DW/2-bit signed.
- MAX_CELL_ID, 1007, largest N_id; N_id port width is $clog2(MAX_CELL_ID).

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous, active-high reset
- N_id_i  in  $clog2(MAX_CELL_ID)  physical cell id
- ibar_SSB_i  in  3  SSB index bits for c_init
- config_valid_i  in  1  one-cycle strobe; latches N_id_i and ibar_SSB_i
- start_i  in  1  one-cycle strobe; request one SSB (3 symbols) output
- ready_o  out  1  sequence buffer valid; start_i accepted
- busy_o  out  1  generating or streaming
- m_axis_out_tdata  out  OUT_DW  subcarrier sample
- m_axis_out_tvalid  out  1  sample valid
- m_axis_out_tready  in  1  downstream ready
- m_axis_out_tlast  out  1  last subcarrier (k=239) of each symbol
- m_axis_out_tuser  out  2  PBCH symbol index 1..3

Behaviour:
- Reset (reset_i sampled high): state IDLE; ready_o, busy_o, tvalid, tlast 0; tdata, tuser 0; pending flag cleared; buffer marked invalid. Applies mid-generation and mid-stream; no further beats after reset.
- c_init = 2^11*(ibar+1)*(floor(N_id/4)+1) + 2^6*(ibar+1) + (N_id mod 4), computed at 31 bits.
  - x1 seeded to 1, taps x^31+x^3+1.
  - x2 seeded to c_init, taps x^31+x^3+x^2+x+1.
  - c(n) = x1 ^ x2.
- Sequencing: c(2m) is stored as bit[1] and c(2m+1) as bit[0] of pair m, in a 144x2 buffer.
- States:
  - IDLE: config_valid_i -> INIT.
  - INIT (1 cycle): load LFSRs.
  - WARMUP: exactly 1600 shifts, discarded (Nc).
  - FILL: 288 shifts into the buffer -> READY.
  - READY: ready_o=1; start_i -> STREAM.
  - STREAM: 720 beats -> READY.
- Latency: config_valid_i sampled at cycle 0 -> ready_o high at cycle 1890 (1+1600+288+1).
- config_valid_i in INIT/WARMUP/FILL: relatch and restart INIT; ready_o stays 0.
- config_valid_i in READY: ready_o drops the next cycle; regenerate.
- config_valid_i in STREAM: latch as pending; finish the SSB using the old buffer; enter INIT after the final handshake.
- start_i outside READY: ignored. busy_o=1 in INIT/WARMUP/FILL/STREAM.
- STREAM order: symbol 1 k=0..239, symbol 2 k=0..239, symbol 3 k=0..239.
- Handshake: beat advances only when tvalid&&tready. tdata/tuser/tlast held stable while stalled; tvalid is never deasserted without a handshake.
- DMRS positions, nu = N_id mod 4:
  - Symbols 1 and 3: all k with k mod 4 == nu.
  - Symbol 2: only k in 0..47 or 192..239 with k mod 4 == nu.
- DMRS index m increments per DMRS position: symbol 1 uses m 0..59, symbol 2 uses 60..83, symbol 3 uses 84..143.
- DMRS sample: re = bit[1] ? -AMPL : +AMPL; im = bit[0] ? -AMPL : +AMPL.
- Non-DMRS positions: tdata = 0.
- tuser = symbol index during all beats of that symbol. tlast = 1 on k=239.
- Back-to-back: start_i on the cycle READY is re-entered starts a new SSB; the buffer is reused without regeneration.

Optional Feature:
- Macro: PBCH_DMRS_MAPPER_DEBUG_EN.
- With it defined: ports debug_dmrs_o[1:0] and debug_dmrs_valid_o are added; valid pulses once per completed pair during FILL (144 pulses); debug_dmrs_o carries {c(2m), c(2m+1)}.
- Without it: ports and logic absent; behaviour otherwise identical.

Test Plan:
- Reset, then N_id=0, ibar=0 (c_init=2112) -> ready_o rises exactly 1890 cycles after config_valid_i; 144 buffered pairs match the py3gpp nrPBCHDMRS golden model.
- Same config, tready=1, start_i:
  - 720 beats, tlast at beats 239/479/719, tuser 1/2/3.
  - Nonzero samples at k=0,4,...,236 (60+24+60=144); each sample is ±11585 per component.
- N_id=3, ibar=5 -> first DMRS at k=3. Symbol 2 has nonzero samples only at k=3..47 and k=195..239. Matches the golden model.
- Random tready (50%) -> identical data sequence to the no-stall run; tdata held during stalls; tvalid never drops without a handshake.
- config_valid_i (N_id=17) at beat 300 -> remaining 420 beats use the old sequence; ready_o returns 1890 cycles after the final handshake; new buffer matches N_id=17.
- reset_i mid-WARMUP and mid-STREAM -> tvalid and ready_o 0 the next cycle; start_i ignored until reconfigured.

Source files
------------

// File: rtl/pbch_dmrs_mapper_if.sv
// AXI-stream bundle for the PBCH DMRS mapper sample output.
// Carries im/re packed in tdata, the PBCH symbol index in tuser, and tlast on the final subcarrier.
interface pbch_dmrs_mapper_if #(
   parameter int OUT_DW = 32
);
   logic [OUT_DW-1:0] tdata;
   logic              tvalid;
   logic              tready;
   logic              tlast;
   logic [1:0]        tuser;

   modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
   modport slave  (input tdata, input tvalid, input tlast, input tuser, output tready);
endinterface

// File: rtl/pbch_dmrs_mapper.sv
// PBCH DMRS generator/mapper: Gold sequence -> 144x2 buffer -> QPSK samples over the SSB region of symbols 1..3.
// Optional debug tap of each buffered pair is enabled by defining PBCH_DMRS_MAPPER_DEBUG_EN.
//
// state   | meaning
// IDLE    | no valid configuration yet
// INIT    | load x1 = 1 and x2 = c_init
// WARMUP  | 1600 discarded shifts (Nc)
// FILL    | 288 shifts packed into 144 bit-pairs
// READY   | buffer valid, waiting for start_i
// STREAM  | 720 subcarrier beats (3 symbols x 240)
module pbch_dmrs_mapper #(
   parameter int OUT_DW      = 32,
   parameter int AMPL        = 11585,
   parameter int MAX_CELL_ID = 1007,
   localparam int NID_W      = $clog2(MAX_CELL_ID)
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic [NID_W-1:0]  N_id_i,
   input  logic [2:0]        ibar_SSB_i,
   input  logic              config_valid_i,
   input  logic              start_i,
   output logic              ready_o,
   output logic              busy_o,
   pbch_dmrs_mapper_if.master m_axis_out
`ifdef PBCH_DMRS_MAPPER_DEBUG_EN
   ,
   output logic [1:0]        debug_dmrs_o,
   output logic              debug_dmrs_valid_o
`endif
);

   localparam int HALF = OUT_DW / 2;
   localparam logic signed [HALF-1:0] A_POS = HALF'(AMPL);
   localparam logic signed [HALF-1:0] A_NEG = -A_POS;

   typedef enum logic [2:0] {
      S_IDLE, S_INIT, S_WARMUP, S_FILL, S_READY, S_STREAM
   } state_t;

   state_t            state_q, state_d;
   logic [NID_W-1:0]  nid_q, nid_d, pend_nid_q, pend_nid_d;
   logic [2:0]        ibar_q, ibar_d, pend_ibar_q, pend_ibar_d;
   logic              pend_q, pend_d;
   logic              buf_valid_q, buf_valid_d;
   logic [30:0]       x1_q, x1_d, x2_q, x2_d;
   logic [10:0]       warm_q, warm_d;
   logic [8:0]        fill_q, fill_d;
   logic              even_q, even_d;
   logic [1:0]        sym_q, sym_d;
   logic [7:0]        k_q, k_d, m_q, m_d;
   logic [1:0]        buf_q [0:143];

   logic              buf_we;
   logic [7:0]        buf_waddr;
   logic [1:0]        buf_wdata;
   logic              c_bit, x1_fb, x2_fb, hs, dmrs_pos;
   logic [30:0]       ib1, q1, c_init;
   logic [1:0]        pair;
   logic signed [HALF-1:0] re_s, im_s;

   assign ib1    = 31'(ibar_q) + 31'd1;
   assign q1     = 31'(nid_q >> 2) + 31'd1;
   assign c_init = ((ib1 * q1) << 11) + (ib1 << 6) + 31'(nid_q[1:0]);

   assign c_bit  = x1_q[0] ^ x2_q[0];
   assign x1_fb  = x1_q[0] ^ x1_q[3];
   assign x2_fb  = x2_q[0] ^ x2_q[1] ^ x2_q[2] ^ x2_q[3];

   // Symbol 2 carries PBCH only on the 48 subcarriers at each edge of the SSB.
   assign dmrs_pos = (k_q[1:0] == nid_q[1:0]) &&
                     ((sym_q != 2'd2) || (k_q < 8'd48) || (k_q >= 8'd192));
   assign hs       = (state_q == S_STREAM) && m_axis_out.tready;

   always_comb begin
      state_d     = state_q;
      nid_d       = nid_q;
      ibar_d      = ibar_q;
      pend_d      = pend_q;
      pend_nid_d  = pend_nid_q;
      pend_ibar_d = pend_ibar_q;
      buf_valid_d = buf_valid_q;
      x1_d        = x1_q;
      x2_d        = x2_q;
      warm_d      = warm_q;
      fill_d      = fill_q;
      even_d      = even_q;
      sym_d       = sym_q;
      k_d         = k_q;
      m_d         = m_q;
      buf_we      = 1'b0;
      buf_waddr   = fill_q[8:1];
      buf_wdata   = {even_q, c_bit};

      unique case (state_q)
         S_IDLE: begin
            if (config_valid_i) begin
               nid_d   = N_id_i;
               ibar_d  = ibar_SSB_i;
               state_d = S_INIT;
            end
         end
         S_INIT: begin
            x1_d        = 31'd1;
            x2_d        = c_init;
            warm_d      = 11'd1599;
            buf_valid_d = 1'b0;
            state_d     = S_WARMUP;
         end
         S_WARMUP: begin
            x1_d = {x1_fb, x1_q[30:1]};
            x2_d = {x2_fb, x2_q[30:1]};
            if (warm_q == 11'd0) begin
               fill_d  = '0;
               state_d = S_FILL;
            end else begin
               warm_d = warm_q - 11'd1;
            end
         end
         S_FILL: begin
            x1_d = {x1_fb, x1_q[30:1]};
            x2_d = {x2_fb, x2_q[30:1]};
            if (!fill_q[0]) even_d = c_bit;
            else            buf_we = 1'b1;
            if (fill_q == 9'd287) begin
               buf_valid_d = 1'b1;
               state_d     = S_READY;
            end else begin
               fill_d = fill_q + 9'd1;
            end
         end
         S_READY: begin
            if (config_valid_i) begin
               nid_d       = N_id_i;
               ibar_d      = ibar_SSB_i;
               buf_valid_d = 1'b0;
               state_d     = S_INIT;
            end else if (start_i) begin
               sym_d   = 2'd1;
               k_d     = '0;
               m_d     = '0;
               state_d = S_STREAM;
            end
         end
         S_STREAM: begin
            // A new config must not disturb nu or the buffer until the SSB is out.
            if (config_valid_i) begin
               pend_d      = 1'b1;
               pend_nid_d  = N_id_i;
               pend_ibar_d = ibar_SSB_i;
            end
            if (hs) begin
               if (dmrs_pos) m_d = m_q + 8'd1;
               if (k_q == 8'd239) begin
                  k_d = '0;
                  if (sym_q == 2'd3) begin
                     if (pend_d) begin
                        nid_d   = pend_nid_d;
                        ibar_d  = pend_ibar_d;
                        pend_d  = 1'b0;
                        state_d = S_INIT;
                     end else begin
                        state_d = S_READY;
                     end
                  end else begin
                     sym_d = sym_q + 2'd1;
                  end
               end else begin
                  k_d = k_q + 8'd1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Reconfiguring while generating restarts from INIT with the new values.
      if (config_valid_i && (state_q == S_INIT || state_q == S_WARMUP || state_q == S_FILL)) begin
         nid_d   = N_id_i;
         ibar_d  = ibar_SSB_i;
         state_d = S_INIT;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q     <= S_IDLE;
         nid_q       <= '0;
         ibar_q      <= '0;
         pend_q      <= 1'b0;
         pend_nid_q  <= '0;
         pend_ibar_q <= '0;
         buf_valid_q <= 1'b0;
         x1_q        <= '0;
         x2_q        <= '0;
         warm_q      <= '0;
         fill_q      <= '0;
         even_q      <= 1'b0;
         sym_q       <= '0;
         k_q         <= '0;
         m_q         <= '0;
      end else begin
         state_q     <= state_d;
         nid_q       <= nid_d;
         ibar_q      <= ibar_d;
         pend_q      <= pend_d;
         pend_nid_q  <= pend_nid_d;
         pend_ibar_q <= pend_ibar_d;
         buf_valid_q <= buf_valid_d;
         x1_q        <= x1_d;
         x2_q        <= x2_d;
         warm_q      <= warm_d;
         fill_q      <= fill_d;
         even_q      <= even_d;
         sym_q       <= sym_d;
         k_q         <= k_d;
         m_q         <= m_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (buf_we) buf_q[buf_waddr] <= buf_wdata;
   end

   assign pair = buf_q[m_q];
   assign re_s = pair[1] ? A_NEG : A_POS;
   assign im_s = pair[0] ? A_NEG : A_POS;

   assign ready_o  = (state_q == S_READY) && buf_valid_q;
   assign busy_o   = (state_q == S_INIT) || (state_q == S_WARMUP) ||
                     (state_q == S_FILL) || (state_q == S_STREAM);

   assign m_axis_out.tvalid = (state_q == S_STREAM);
   assign m_axis_out.tdata  = ((state_q == S_STREAM) && dmrs_pos) ? {im_s, re_s} : '0;
   assign m_axis_out.tuser  = (state_q == S_STREAM) ? sym_q : 2'd0;
   assign m_axis_out.tlast  = (state_q == S_STREAM) && (k_q == 8'd239);

`ifdef PBCH_DMRS_MAPPER_DEBUG_EN
   assign debug_dmrs_valid_o = (state_q == S_FILL) && fill_q[0];
   assign debug_dmrs_o       = {even_q, c_bit};
`endif

endmodule

// File: tb/tb_pbch_dmrs_mapper.sv
// Self-checking bench for pbch_dmrs_mapper: Gold-sequence reference built from the recurrences,
// random tready, mid-stream reconfiguration and reset cases.
module tb_pbch_dmrs_mapper;
   localparam int OUT_DW = 32;
   localparam int AMPL   = 11585;
   localparam int NID_W  = 10;

   logic             clk_i = 1'b0;
   logic             reset_i;
   logic [NID_W-1:0] N_id_i;
   logic [2:0]       ibar_SSB_i;
   logic             config_valid_i;
   logic             start_i;
   logic             ready_o;
   logic             busy_o;

   pbch_dmrs_mapper_if #(.OUT_DW(OUT_DW)) m_axis_out ();

`ifdef PBCH_DMRS_MAPPER_DEBUG_EN
   logic [1:0] debug_dmrs_o;
   logic       debug_dmrs_valid_o;
`endif

   pbch_dmrs_mapper #(.OUT_DW(OUT_DW), .AMPL(AMPL), .MAX_CELL_ID(1007)) dut (
      .clk_i          (clk_i),
      .reset_i        (reset_i),
      .N_id_i         (N_id_i),
      .ibar_SSB_i     (ibar_SSB_i),
      .config_valid_i (config_valid_i),
      .start_i        (start_i),
      .ready_o        (ready_o),
      .busy_o         (busy_o),
      .m_axis_out     (m_axis_out)
`ifdef PBCH_DMRS_MAPPER_DEBUG_EN
      ,
      .debug_dmrs_o       (debug_dmrs_o),
      .debug_dmrs_valid_o (debug_dmrs_valid_o)
`endif
   );

   always #5 clk_i = ~clk_i;

   int n_vec = 0;
   int n_err = 0;

   logic [31:0] exp_data [720];
   logic [1:0]  exp_user [720];
   logic        exp_last [720];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_vec++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // Reference: Gold sequence from the TS 38.211 recurrences over plain arrays, then SSB mapping.
   task automatic build_model(input int nid, input int ibar);
      bit x1 [1919];
      bit x2 [1919];
      bit c  [288];
      int cinit, m, idx, nu;
      logic [15:0] re, im;
      cinit = 2048 * (ibar + 1) * (nid / 4 + 1) + 64 * (ibar + 1) + (nid % 4);
      for (int n = 0; n < 31; n++) begin
         x1[n] = (n == 0);
         x2[n] = ((cinit >> n) & 1) != 0;
      end
      for (int n = 0; n + 31 < 1919; n++) begin
         x1[n+31] = x1[n+3] ^ x1[n];
         x2[n+31] = x2[n+3] ^ x2[n+2] ^ x2[n+1] ^ x2[n];
      end
      for (int n = 0; n < 288; n++) c[n] = x1[n+1600] ^ x2[n+1600];
      nu = nid % 4;
      m = 0;
      idx = 0;
      for (int sym = 1; sym <= 3; sym++) begin
         for (int k = 0; k < 240; k++) begin
            exp_user[idx] = 2'(sym);
            exp_last[idx] = (k == 239);
            if ((k % 4 == nu) && (sym != 2 || k < 48 || k >= 192)) begin
               re = c[2*m]   ? 16'(-AMPL) : 16'(AMPL);
               im = c[2*m+1] ? 16'(-AMPL) : 16'(AMPL);
               exp_data[idx] = {im, re};
               m++;
            end else begin
               exp_data[idx] = 32'd0;
            end
            idx++;
         end
      end
   endtask

   task automatic configure(input int nid, input int ibar);
      N_id_i         = NID_W'(nid);
      ibar_SSB_i     = 3'(ibar);
      config_valid_i = 1'b1;
      @(posedge clk_i); #1;
      config_valid_i = 1'b0;
      check("cfg_ready_low", ready_o, 0);
      check("cfg_busy", busy_o, 1);
   endtask

   // Entered 1 time unit after the edge that sampled the strobe (or final handshake), i.e. in cycle 1.
   task automatic wait_ready(input string tag);
      int cnt;
      cnt = 0;
      while (!ready_o && cnt < 2500) begin
         @(posedge clk_i); #1;
         cnt++;
      end
      check(tag, cnt + 1, 1890);
   endtask

   task automatic run_stream(input bit rnd_ready, input int pend_beat, input int pend_nid,
                             input int pend_ibar, input int abort_beat,
                             output int nz_cnt, output int first_nz);
      int beat, cyc;
      bit hs, stalled, pend_sent;
      logic [31:0] prev_data;
      beat = 0; cyc = 0; nz_cnt = 0; first_nz = -1;
      stalled = 0; pend_sent = 0; prev_data = '0;
      start_i = 1'b1;
      @(posedge clk_i); #1;
      start_i = 1'b0;
      while (beat < 720 && cyc < 5000) begin
         if (beat == abort_beat) begin
            reset_i = 1'b1;
            @(posedge clk_i); #1;
            reset_i = 1'b0;
            check("rst_stream_tvalid", m_axis_out.tvalid, 0);
            check("rst_stream_ready", ready_o, 0);
            check("rst_stream_busy", busy_o, 0);
            return;
         end
         check("tvalid", m_axis_out.tvalid, 1);
         check("tdata", m_axis_out.tdata, exp_data[beat]);
         check("tuser", m_axis_out.tuser, exp_user[beat]);
         check("tlast", m_axis_out.tlast, exp_last[beat]);
         if (stalled) check("stall_hold", m_axis_out.tdata, prev_data);
         prev_data = m_axis_out.tdata;
         m_axis_out.tready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         if (beat == pend_beat && !pend_sent) begin
            N_id_i         = NID_W'(pend_nid);
            ibar_SSB_i     = 3'(pend_ibar);
            config_valid_i = 1'b1;
            pend_sent      = 1'b1;
         end
         hs      = m_axis_out.tvalid && m_axis_out.tready;
         stalled = m_axis_out.tvalid && !m_axis_out.tready;
         if (hs && m_axis_out.tdata != 32'd0) begin
            nz_cnt++;
            if (first_nz < 0) first_nz = beat;
         end
         @(posedge clk_i); #1;
         config_valid_i = 1'b0;
         if (hs) beat++;
         cyc++;
      end
      check("stream_beats", beat, 720);
   endtask

   initial begin
      #900_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int nz, fk, nid, ibar, pnid, pibar;
      reset_i = 1'b1; N_id_i = '0; ibar_SSB_i = '0; config_valid_i = 1'b0; start_i = 1'b0;
      m_axis_out.tready = 1'b1;
      repeat (3) @(posedge clk_i);
      #1 reset_i = 1'b0;
      check("rst_ready", ready_o, 0);
      check("rst_busy", busy_o, 0);
      check("rst_tvalid", m_axis_out.tvalid, 0);
      check("rst_tlast", m_axis_out.tlast, 0);
      check("rst_tdata", m_axis_out.tdata, 0);
      check("rst_tuser", m_axis_out.tuser, 0);

      // N_id=0, ibar=0 with tready held high, then a back-to-back SSB under random stalls
      configure(0, 0);
      wait_ready("latency_nid0");
      build_model(0, 0);
      run_stream(1'b0, -1, 0, 0, -1, nz, fk);
      check("nz_count_nid0", nz, 144);
      check("first_dmrs_nid0", fk, 0);
      check("ready_after_ssb", ready_o, 1);
      run_stream(1'b1, -1, 0, 0, -1, nz, fk);
      check("nz_count_b2b", nz, 144);

      // N_id=3, ibar=5: DMRS offset 3
      configure(3, 5);
      wait_ready("latency_nid3");
      build_model(3, 5);
      run_stream(1'b1, -1, 0, 0, -1, nz, fk);
      check("first_dmrs_nid3", fk, 3);
      check("nz_count_nid3", nz, 144);

      // Reconfigure to N_id=17 at beat 300; remainder uses old buffer
      pibar = $urandom_range(0, 7);
      run_stream(1'b1, 300, 17, pibar, -1, nz, fk);
      check("pend_ready_low", ready_o, 0);
      wait_ready("latency_pending");
      build_model(17, pibar);
      run_stream(1'b0, -1, 0, 0, -1, nz, fk);
      check("first_dmrs_nid17", fk, 1);

      // Reconfigure while READY
      nid = $urandom_range(0, 1007); ibar = $urandom_range(0, 7);
      configure(nid, ibar);
      wait_ready("latency_from_ready");
      build_model(nid, ibar);
      run_stream(1'b1, -1, 0, 0, -1, nz, fk);
      check("first_dmrs_rnd", fk, nid % 4);

      // Reset during WARMUP, then start_i must be ignored
      configure($urandom_range(0, 1007), $urandom_range(0, 7));
      repeat (500) @(posedge clk_i);
      #1 reset_i = 1'b1;
      @(posedge clk_i); #1;
      reset_i = 1'b0;
      check("rst_warm_tvalid", m_axis_out.tvalid, 0);
      check("rst_warm_ready", ready_o, 0);
      check("rst_warm_busy", busy_o, 0);
      start_i = 1'b1;
      @(posedge clk_i); #1;
      start_i = 1'b0;
      repeat (4) @(posedge clk_i);
      #1;
      check("ign_start_tvalid", m_axis_out.tvalid, 0);
      check("ign_start_busy", busy_o, 0);

      // Reset during STREAM, then start_i must be ignored
      nid = $urandom_range(0, 1007); ibar = $urandom_range(0, 7);
      configure(nid, ibar);
      wait_ready("latency_pre_abort");
      build_model(nid, ibar);
      run_stream(1'b1, -1, 0, 0, 150, nz, fk);
      start_i = 1'b1;
      @(posedge clk_i); #1;
      start_i = 1'b0;
      repeat (4) @(posedge clk_i);
      #1;
      check("ign_start2_tvalid", m_axis_out.tvalid, 0);
      check("ign_start2_ready", ready_o, 0);

      // Random configurations
      for (int i = 0; i < 2; i++) begin
         nid = $urandom_range(0, 1007); ibar = $urandom_range(0, 7);
         configure(nid, ibar);
         wait_ready("latency_rnd");
         build_model(nid, ibar);
         run_stream(1'b1, -1, 0, 0, -1, nz, fk);
         check("nz_count_rnd", nz, 144);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
